// File: rtl/rat_ctrl_pkg.sv
// Shared control-path types and constants for the RAT pipeline control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rat_ctrl_pkg;

  localparam int PC_WIDTH = 10;

  localparam logic [PC_WIDTH-1:0] INT_VECTOR_DEFAULT = 10'h3FF;

  // Interrupt entry sequence; every non-IDLE state lasts exactly one cycle.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    PUSH   = 3'd2,
    VECTOR = 3'd3,
    REFILL = 3'd4
  } int_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
// Latency: rise asserts STAGES clock edges after d goes high, for one cycle.
// Backpressure: none; every synchronized 0->1 transition produces one rise pulse.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edge is decoded from registers only, so no input reaches rise combinationally.
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: latches one pending request, waits for a safe point, then drain/push/vector/refill.
// Latency: irq edge to irq_pending in SYNC_STAGES+1 edges; accept to return-to-IDLE in 5 edges, flush high 4 cycles.
// Backpressure: accept waits while i_flag is low, ex_branch or stall_in is high; extra edges while pending are dropped.
module interrupt_sequencer
  import rat_ctrl_pkg::*;
#(
  parameter int unsigned VECTOR_ADDR = INT_VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_in,
  input  logic                i_flag,
  input  logic                ex_branch,
  input  logic                stall_in,
  input  logic [PC_WIDTH-1:0] resume_pc,
  output logic                flush,
  output logic                int_cycle,
  output logic [PC_WIDTH-1:0] ret_addr,
  output logic                pc_vec_ld,
  output logic                busy,
  output logic                irq_pending
);

  // The vector itself is applied by PC control; here we only guard against a
  // value that cannot be represented in the PC.
  if ((VECTOR_ADDR >> PC_WIDTH) != 0) begin : g_bad_vector
    $error("interrupt_sequencer: VECTOR_ADDR does not fit in the PC width");
  end

  // A single flop would not resolve metastability on irq_in.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("interrupt_sequencer: SYNC_STAGES must be at least 2");
  end

  int_state_t          state_q;
  int_state_t          state_d;
  logic                pending_q;
  logic [PC_WIDTH-1:0] ret_addr_q;
  logic                irq_rise;
  logic                accept;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (irq_in),
    .rise (irq_rise)
  );

  // Only start from IDLE, and never while EX holds control flow or the pipeline is already stalling.
  assign accept = (state_q == IDLE) & pending_q & i_flag & ~ex_branch & ~stall_in;

  // Next-state: wait in IDLE for accept, then walk the fixed one-cycle-per-state chain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRAIN;
      DRAIN:   state_d = PUSH;
      PUSH:    state_d = VECTOR;
      VECTOR:  state_d = REFILL;
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pending request and captured return address; a new edge beats the clear on PUSH entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      ret_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= irq_rise | (pending_q & (state_q != DRAIN));
      if (accept) begin
        ret_addr_q <= resume_pc;
      end
    end
  end

  // All outputs are decodes of registered state.
  assign busy        = (state_q != IDLE);
  assign flush       = (state_q != IDLE);
  assign int_cycle   = (state_q == PUSH);
  assign pc_vec_ld   = (state_q == VECTOR);
  assign irq_pending = pending_q;
  assign ret_addr    = ret_addr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed from the sequencing rules.
module tb_interrupt_sequencer;

  logic       clk;
  logic       rst;
  logic       irq_in;
  logic       i_flag;
  logic       ex_branch;
  logic       stall_in;
  logic [9:0] resume_pc;
  logic       flush;
  logic       int_cycle;
  logic [9:0] ret_addr;
  logic       pc_vec_ld;
  logic       busy;
  logic       irq_pending;

  int n_checks = 0;
  int n_errors = 0;
  int flush_cycles = 0;
  int fc0;

  interrupt_sequencer #(
    .VECTOR_ADDR (32'h3FF),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .i_flag      (i_flag),
    .ex_branch   (ex_branch),
    .stall_in    (stall_in),
    .resume_pc   (resume_pc),
    .flush       (flush),
    .int_cycle   (int_cycle),
    .ret_addr    (ret_addr),
    .pc_vec_ld   (pc_vec_ld),
    .busy        (busy),
    .irq_pending (irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count cycles with flush high, sampled mid-cycle.
  always @(negedge clk) begin
    if (flush) flush_cycles <= flush_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    irq_in    = 1'b0;
    i_flag    = 1'b0;
    ex_branch = 1'b0;
    stall_in  = 1'b0;
    resume_pc = 10'h000;

    // Reset state
    step(2);
    check("rst_busy",    32'(busy),        0);
    check("rst_flush",   32'(flush),       0);
    check("rst_int",     32'(int_cycle),   0);
    check("rst_vec",     32'(pc_vec_ld),   0);
    check("rst_pend",    32'(irq_pending), 0);
    check("rst_ret",     32'(ret_addr),    0);
    rst = 1'b0;
    step(1);

    // Basic sequence, idle pipeline
    i_flag    = 1'b1;
    resume_pc = 10'h025;
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(1);
    check("t2_pend_e2",   32'(irq_pending), 0);
    step(1);
    check("t2_pend_e3",   32'(irq_pending), 1);
    check("t2_busy_e3",   32'(busy),        0);
    fc0 = flush_cycles;
    step(1);
    check("t2_drain_busy", 32'(busy),        1);
    check("t2_drain_fl",   32'(flush),       1);
    check("t2_drain_int",  32'(int_cycle),   0);
    check("t2_drain_pend", 32'(irq_pending), 1);
    check("t2_ret",        32'(ret_addr),    32'h025);
    resume_pc = 10'h100;
    step(1);
    check("t2_push_int",  32'(int_cycle),   1);
    check("t2_push_vec",  32'(pc_vec_ld),   0);
    check("t2_push_pend", 32'(irq_pending), 0);
    step(1);
    check("t2_vec_ld",    32'(pc_vec_ld),   1);
    check("t2_vec_int",   32'(int_cycle),   0);
    step(1);
    check("t2_refill_fl", 32'(flush),       1);
    check("t2_refill_vec", 32'(pc_vec_ld),  0);
    step(1);
    check("t2_idle_fl",   32'(flush),       0);
    check("t2_idle_busy", 32'(busy),        0);
    check("t2_ret_hold",  32'(ret_addr),    32'h025);
    check("t2_flush_len", 32'(flush_cycles - fc0), 4);

    // i_flag low: request held, never taken
    i_flag = 1'b0;
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(2);
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("t3_hold", {30'd0, busy, irq_pending}, 32'b01);
    end
    i_flag = 1'b1;
    step(1);
    check("t3_start",     32'(busy),        1);
    check("t3_ret",       32'(ret_addr),    32'h100);
    step(4);
    check("t3_done",      32'(busy),        0);
    check("t3_pend_clr",  32'(irq_pending), 0);

    // ex_branch delays accept
    ex_branch = 1'b1;
    resume_pc = 10'h0AA;
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(2);
    check("t4_pend",      32'(irq_pending), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t4_wait", 32'(busy), 0);
    end
    ex_branch = 1'b0;
    resume_pc = 10'h0AB;
    step(1);
    check("t4_start",     32'(busy),        1);
    check("t4_ret",       32'(ret_addr),    32'h0AB);
    step(4);
    check("t4_done",      32'(busy),        0);

    // Edge coinciding with PUSH entry re-arms; edge at DRAIN entry is dropped
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(1);
    irq_in = 1'b1; step(1);
    check("t5_pend",      32'(irq_pending), 1);
    irq_in = 1'b0; step(1);
    check("t5_drain",     32'(busy),        1);
    step(1);
    check("t5_push_int",  32'(int_cycle),   1);
    check("t5_set_wins",  32'(irq_pending), 1);
    step(1);
    check("t5_vec",       32'(pc_vec_ld),   1);
    irq_in = 1'b1; step(1);
    irq_in = 1'b0;
    check("t5_refill",    32'(flush),       1);
    step(1);
    check("t5_idle",      32'(busy),        0);
    check("t5_idle_pend", 32'(irq_pending), 1);
    step(1);
    check("t5_second",    32'(busy),        1);
    step(1);
    check("t5_push2_int", 32'(int_cycle),   1);
    check("t5_dropped",   32'(irq_pending), 0);
    step(4);
    check("t5_done",      32'(busy),        0);
    check("t5_no_third",  32'(irq_pending), 0);

    // stall_in 1,0,1: accept only in the unstalled cycle
    stall_in = 1'b1;
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(2);
    check("t6_pend",      32'(irq_pending), 1);
    resume_pc = 10'h111;
    step(1);
    check("t6_stall1",    32'(busy),        0);
    stall_in  = 1'b0;
    resume_pc = 10'h222;
    step(1);
    check("t6_accept",    32'(busy),        1);
    check("t6_ret",       32'(ret_addr),    32'h222);
    stall_in  = 1'b1;
    resume_pc = 10'h333;
    step(1);
    check("t6_push",      32'(int_cycle),   1);
    check("t6_ret_hold",  32'(ret_addr),    32'h222);
    step(3);
    check("t6_done",      32'(busy),        0);
    stall_in = 1'b0;

    // Reset mid-PUSH with a request pending
    resume_pc = 10'h055;
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(1);
    irq_in = 1'b1; step(1);
    irq_in = 1'b0; step(2);
    check("t7_push",      32'(int_cycle),   1);
    check("t7_pend",      32'(irq_pending), 1);
    rst = 1'b1;
    step(1);
    check("t7_busy",      32'(busy),        0);
    check("t7_flush",     32'(flush),       0);
    check("t7_int",       32'(int_cycle),   0);
    check("t7_vec",       32'(pc_vec_ld),   0);
    check("t7_pend_clr",  32'(irq_pending), 0);
    check("t7_ret",       32'(ret_addr),    0);
    step(1);
    check("t7_hold_busy", 32'(busy),        0);
    rst = 1'b0;
    step(3);
    check("t7_after",     {30'd0, busy, irq_pending}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequences interrupt entry for the pipelined CPU. Synchronizes the external interrupt line, holds a single pending request, and waits for a safe point in execute. It then flushes fetch/decode, drives the decoder's interrupt cycle (push return address, shadow flags, clear I), and loads the PC with the vector. Sits beside `pipeline_control`; its `flush` is ORed into the existing fetch-stall/decode-nop signals and `pc_vec_ld` has priority over normal PC control.

## Interface
- `VECTOR_ADDR`, 10'h3FF, interrupt vector loaded into PC
- `SYNC_STAGES`, 2, synchronizer depth for `irq_in` (≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `irq_in`  in  1  external interrupt, asynchronous, rising-edge significant
- `i_flag`  in  1  interrupt enable flag (I_FLAG output)
- `ex_branch`  in  1  EX holds a control-flow instruction (branch/call/ret/reti, taken or not)
- `stall_in`  in  1  pipeline_control currently stalling fetch or inserting a nop
- `resume_pc`  in  10  address of the oldest in-flight instruction younger than EX
- `flush`  out  1  hold fetch, force decode nop
- `int_cycle`  out  1  drives decoder INT for one cycle
- `ret_addr`  out  10  return address for the scratch-RAM push
- `pc_vec_ld`  out  1  load PC with `VECTOR_ADDR`
- `busy`  out  1  sequence in progress
- `irq_pending`  out  1  latched, not-yet-serviced request

## Operation
- `irq_in` passes through `SYNC_STAGES` flops, then a rising-edge detector. An edge sets `pending`.
- `pending` is single-deep. Extra edges while it is set are dropped.
- `pending` clears on entry to PUSH. If a new edge arrives in that same cycle, the set wins.
- Accept condition, checked only in IDLE: `pending & i_flag & !ex_branch & !stall_in`. On accept, capture `resume_pc` into `ret_addr`.
- If `i_flag` is low, `pending` is held indefinitely and is not taken.
- FSM states: IDLE → DRAIN → PUSH → VECTOR → REFILL → IDLE. Every non-IDLE state advances unconditionally after 1 cycle.
  - DRAIN: `flush`=1. The EX instruction retires to WB.
  - PUSH: `flush`=1, `int_cycle`=1. Decoder pushes `ret_addr` and clears I.
  - VECTOR: `flush`=1, `pc_vec_ld`=1.
  - REFILL: `flush`=1. Covers the synchronous prog ROM latency.
- `busy` = (state != IDLE). `irq_pending` = `pending`.
- Reset: state IDLE; `pending`, sync flops and edge-detect history 0; `ret_addr` 0; all 1-bit outputs 0. rst overrides every other input.
- Reset mid-sequence: IDLE on the next edge, pending request discarded, no partial push/vector outputs after that edge.
- No arithmetic. `ret_addr` is a copy of `resume_pc` with no wrap handling (10-bit PC space).

## Timing
- All outputs are registered or decoded from registered state only. No combinational input→output path.
- `irq_in` rising edge to `irq_pending`=1: `SYNC_STAGES`+1 clock edges.
- If the accept condition holds at edge N, the state at each subsequent edge is:
  - N+1: DRAIN
  - N+2: PUSH (`int_cycle` high)
  - N+3: VECTOR (`pc_vec_ld` high)
  - N+4: REFILL
  - N+5: IDLE
- `flush` is high for exactly 4 cycles. First vector instruction reaches decode at N+6.
- Earliest re-accept: the cycle after return to IDLE, if `i_flag` is set again. In practice this is after RETIE.

## Structure
- Shared package `rat_ctrl_pkg`:
  - `int_state_t` enum (IDLE, DRAIN, PUSH, VECTOR, REFILL)
  - `INT_VECTOR_DEFAULT` = 10'h3FF
  - `PC_WIDTH` = 10
- Sub-module `sync_edge_detect` (parameter `STAGES`; ports `clk`, `rst`, `d`, `rise`), reusable for other async inputs.
- Top level: pending flop, FSM, `ret_addr` register.

## Test plan
- rst high for 2 cycles mid-PUSH → IDLE next edge, `int_cycle`/`pc_vec_ld`/`flush`/`irq_pending` = 0, `ret_addr` = 0.
- `i_flag`=1, idle pipeline, `resume_pc`=10'h025, pulse `irq_in` → `irq_pending` after 3 edges; `int_cycle` 2 cycles after accept; `ret_addr`=10'h025; `pc_vec_ld` 1 cycle later; `flush` high exactly 4 cycles.
- `i_flag`=0, pulse `irq_in` → `irq_pending` stays 1 for 50 cycles with no `busy`. Raise `i_flag` → sequence starts the next cycle.
- `ex_branch`=1 for 3 cycles while pending → accept delayed until the first cycle with `ex_branch`=0.
- Second `irq_in` edge during the PUSH cycle → pending set again. After REFILL with `i_flag`=1, a second full sequence runs. Third edge during DRAIN → dropped.
- `stall_in` toggling 1,0,1 with pending → accept only on the cycle `stall_in`=0. Captured `ret_addr` matches `resume_pc` in that cycle.
